// File: rtl/fft_bfly_ctrl.sv
// Radix-2 in-place FFT butterfly sequencer.
// Walks LOG2PTS stages of PTS/2 butterflies. Each butterfly issues one read pair plus a twiddle
// index. The matching write-back pair follows D = BF_LAT + 1 cycles later through a shift
// pipeline. A stage drains its pipeline completely before the next stage issues any read, so
// in-place updates never race.
// Optional feature: define FFT_CTRL_CYCLE_CNT_EN to add a 16-bit cyc_cnt output that counts
// the busy cycles of the most recent pass.
module fft_bfly_ctrl #(
  parameter int unsigned LOG2PTS = 3,
  parameter int unsigned BF_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [LOG2PTS-1:0] rd_addr_a,
  output logic [LOG2PTS-1:0] rd_addr_b,
  output logic [LOG2PTS-2:0] tw_idx,
  output logic               wr_en,
  output logic [LOG2PTS-1:0] wr_addr_a,
  output logic [LOG2PTS-1:0] wr_addr_b,
`ifdef FFT_CTRL_CYCLE_CNT_EN
  output logic [15:0]        cyc_cnt,
`endif
  output logic [1:0]         stage
);

  localparam int unsigned PTS  = 1 << LOG2PTS;
  localparam int unsigned HALF = PTS / 2;
  localparam int unsigned D    = BF_LAT + 1;
  localparam int unsigned KW   = LOG2PTS - 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     stage_q, stage_d;
  logic [KW-1:0]  k_q, k_d;
  logic [2:0]     dcnt_q, dcnt_d;
  logic           done_q, done_d;

  // Write-back delay line; index D-1 is the oldest entry and drives the write port.
  logic               wr_pipe_en_q [D];
  logic [LOG2PTS-1:0] wr_pipe_a_q  [D];
  logic [LOG2PTS-1:0] wr_pipe_b_q  [D];

  // Butterfly address arithmetic
  logic [LOG2PTS-1:0] k_ext;
  logic [LOG2PTS-1:0] span;
  logic [LOG2PTS-1:0] mask;
  logic [LOG2PTS-1:0] addr_a;
  logic [LOG2PTS-1:0] addr_b;
  logic [KW-1:0]      tw_lo;
  logic [KW-1:0]      tw_val;
  logic [2:0]         hi_shift;
  logic [2:0]         tw_shift;

  // State register: sync reset forces IDLE and clears all counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      stage_q <= '0;
      k_q     <= '0;
      dcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      dcnt_q  <= dcnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: RUN issues HALF butterflies, DRAIN waits D cycles for the last write.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          stage_d = '0;
          k_d     = '0;
          dcnt_d  = '0;
        end
      end
      StRun: begin
        k_d = k_q + 1'b1;
        if (k_q == KW'(HALF - 1)) begin
          state_d = StDrain;
          k_d     = '0;
          dcnt_d  = '0;
        end
      end
      StDrain: begin
        dcnt_d = dcnt_q + 3'd1;
        // dcnt_q == D-1 is the cycle in which the final write of this stage appears.
        if (dcnt_q == 3'(D - 1)) begin
          dcnt_d = '0;
          k_d    = '0;
          if (stage_q == 2'(LOG2PTS - 1)) begin
            state_d = StIdle;
            stage_d = '0;
            done_d  = 1'b1;
          end else begin
            state_d = StRun;
            stage_d = stage_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Butterfly k of stage s: a = (k >> s) << (s+1) | (k mod 2^s), b = a + 2^s.
  always_comb begin
    k_ext    = {1'b0, k_q};
    span     = LOG2PTS'(1) << stage_q;
    mask     = span - LOG2PTS'(1);
    hi_shift = {1'b0, stage_q} + 3'd1;
    tw_shift = 3'(KW) - {1'b0, stage_q};
    addr_a   = ((k_ext >> stage_q) << hi_shift) | (k_ext & mask);
    addr_b   = addr_a + span;
    tw_lo    = k_q & mask[KW-1:0];
    tw_val   = tw_lo << tw_shift;
  end

  // Read-side outputs; addresses are forced to zero whenever no read is issued.
  always_comb begin
    busy      = (state_q != StIdle);
    rd_en     = (state_q == StRun);
    done      = done_q;
    stage     = stage_q;
    rd_addr_a = rd_en ? addr_a : '0;
    rd_addr_b = rd_en ? addr_b : '0;
    tw_idx    = rd_en ? tw_val : '0;
  end

  // Write-back shift pipeline; reset flushes in-flight butterflies so their writes never occur.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(D); i++) begin
        wr_pipe_en_q[i] <= 1'b0;
        wr_pipe_a_q[i]  <= '0;
        wr_pipe_b_q[i]  <= '0;
      end
    end else begin
      wr_pipe_en_q[0] <= rd_en;
      wr_pipe_a_q[0]  <= rd_addr_a;
      wr_pipe_b_q[0]  <= rd_addr_b;
      for (int i = 1; i < int'(D); i++) begin
        wr_pipe_en_q[i] <= wr_pipe_en_q[i-1];
        wr_pipe_a_q[i]  <= wr_pipe_a_q[i-1];
        wr_pipe_b_q[i]  <= wr_pipe_b_q[i-1];
      end
    end
  end

  // Write-side outputs come straight off the oldest pipeline entry (already zero when idle).
  always_comb begin
    wr_en     = wr_pipe_en_q[D-1];
    wr_addr_a = wr_pipe_a_q[D-1];
    wr_addr_b = wr_pipe_b_q[D-1];
  end

`ifdef FFT_CTRL_CYCLE_CNT_EN
  logic [15:0] cyc_cnt_q;

  // Busy-cycle counter: cleared on an accepted start, held after done.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt_q <= '0;
    end else if ((state_q == StIdle) && start) begin
      cyc_cnt_q <= '0;
    end else if (state_q != StIdle) begin
      cyc_cnt_q <= cyc_cnt_q + 16'd1;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_fft_bfly_ctrl.sv
// Scoreboard bench for fft_bfly_ctrl. A timeline reference model derives the expected outputs
// of each cycle from the accepted start time and pushes them into a queue; a negedge monitor
// pops and compares them against the DUT.
module tb_fft_bfly_ctrl;

  localparam int LOG2PTS = 3;
  localparam int BF_LAT  = 1;
  localparam int PTS     = 1 << LOG2PTS;
  localparam int HALF    = PTS / 2;
  localparam int D       = BF_LAT + 1;
  localparam int L       = HALF + D;
  localparam int TOTAL   = LOG2PTS * L;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               busy, done, rd_en, wr_en;
  logic [LOG2PTS-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [LOG2PTS-2:0] tw_idx;
  logic [1:0]         stage;
`ifdef FFT_CTRL_CYCLE_CNT_EN
  logic [15:0]        cyc_cnt;
`endif

  fft_bfly_ctrl #(
    .LOG2PTS(LOG2PTS),
    .BF_LAT (BF_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .tw_idx   (tw_idx),
    .wr_en    (wr_en),
    .wr_addr_a(wr_addr_a),
    .wr_addr_b(wr_addr_b),
`ifdef FFT_CTRL_CYCLE_CNT_EN
    .cyc_cnt  (cyc_cnt),
`endif
    .stage    (stage)
  );

  always #5 clk = ~clk;

  typedef struct {
    int busy, done, rd_en, ra, rb, tw, wr_en, wa, wb, stage, cyc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  // Model state
  bit armed    = 0;
  bit active   = 0;
  int t0       = 0;
  int n        = 0;
  int busy_now = 0;
  int cyc_m    = 0;

  function automatic void bfly(input int s, input int k, output int a, output int b,
                               output int tw);
    int sp;
    sp = 1 << s;
    a  = (k / sp) * 2 * sp + (k % sp);
    b  = a + sp;
    tw = (k % sp) * (PTS / (2 * sp));
  endfunction

  // Reference model: compute expected outputs of the cycle that follows this edge.
  always @(posedge clk) begin
    exp_t e;
    int   rel, s, o, a, b, tw;
    e = '{default: 0};
    if (rst) begin
      armed  = 1;
      active = 0;
      cyc_m  = 0;
    end else if (armed && start && busy_now == 0) begin
      active = 1;
      t0     = n;
    end
    n = n + 1;
    if (active) begin
      rel = n - t0 - 1;
      if (rel > TOTAL) begin
        active = 0;
      end else begin
        cyc_m = (rel < TOTAL) ? rel : TOTAL;
        if (rel == TOTAL) begin
          e.done = 1;
        end else begin
          e.busy  = 1;
          s       = rel / L;
          o       = rel % L;
          e.stage = s;
          if (o < HALF) begin
            bfly(s, o, a, b, tw);
            e.rd_en = 1; e.ra = a; e.rb = b; e.tw = tw;
          end
          if (o >= D) begin
            bfly(s, o - D, a, b, tw);
            e.wr_en = 1; e.wa = a; e.wb = b;
          end
        end
      end
    end
    e.cyc    = cyc_m;
    busy_now = e.busy;
    if (armed) exp_q.push_back(e);
  end

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  // Monitor: compares every presented cycle against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("busy",      int'(busy),      e.busy);
      check("done",      int'(done),      e.done);
      check("rd_en",     int'(rd_en),     e.rd_en);
      check("rd_addr_a", int'(rd_addr_a), e.ra);
      check("rd_addr_b", int'(rd_addr_b), e.rb);
      check("tw_idx",    int'(tw_idx),    e.tw);
      check("wr_en",     int'(wr_en),     e.wr_en);
      check("wr_addr_a", int'(wr_addr_a), e.wa);
      check("wr_addr_b", int'(wr_addr_b), e.wb);
      check("stage",     int'(stage),     e.stage);
`ifdef FFT_CTRL_CYCLE_CNT_EN
      check("cyc_cnt",   int'(cyc_cnt),   e.cyc);
`endif
    end
  end

  task automatic drive(input bit s, input bit r, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      start = s;
      rst   = r;
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    // Reset asserted together with start: reset must win.
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #2;
    drive(1'b1, 1'b1, 1);
    drive(1'b0, 1'b0, 2);
    // Pass with an ignored mid-pass start, then start held across done.
    drive(1'b1, 1'b0, 1);
    drive(1'b0, 1'b0, 7);
    drive(1'b1, 1'b0, 1);
    drive(1'b0, 1'b0, 10);
    drive(1'b1, 1'b0, 2);
    // Reset in the middle of the second pass, then a clean restart.
    drive(1'b0, 1'b0, 8);
    drive(1'b0, 1'b1, 1);
    drive(1'b0, 1'b0, 1);
    drive(1'b1, 1'b0, 1);
    drive(1'b0, 1'b0, 22);
    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 9) < 3), ($urandom_range(0, 99) == 0), $urandom_range(1, 4));
    end
    drive(1'b0, 1'b0, TOTAL + 4);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fft_bfly_ctrl.md
FFT_BFLY_CTRL -- requirements
Module: fft_bfly_ctrl

Interface
- REQ-001: Parameter LOG2PTS, default 3, log2 of FFT point count PTS; legal range 2..4.
- REQ-002: Parameter BF_LAT, default 1, butterfly datapath latency in cycles, excluding the 1-cycle memory read; legal range 1..4.
- REQ-003: The block SHALL have exactly one clock and reset; reset is synchronous and active-high.
- REQ-004: clk  in  1  rising-edge clock.
- REQ-005: rst  in  1  synchronous active-high reset.
- REQ-006: start  in  1  request one complete FFT pass; sampled in IDLE only.
- REQ-007: busy  out  1  high while a pass is in progress.
- REQ-008: done  out  1  single-cycle pulse at the end of a pass.
- REQ-009: rd_en  out  1  sample-memory read strobe for one butterfly pair.
- REQ-010: rd_addr_a, rd_addr_b  out  LOG2PTS each  read addresses of the upper and lower butterfly inputs.
- REQ-011: tw_idx  out  LOG2PTS-1  twiddle ROM index for the issued butterfly.
- REQ-012: wr_en  out  1  write-back strobe for butterfly results.
- REQ-013: wr_addr_a, wr_addr_b  out  LOG2PTS each  in-place write-back addresses.
- REQ-014: stage  out  2  current radix-2 stage, 0..LOG2PTS-1.

Function
- REQ-015: The FSM SHALL have the states IDLE, RUN and DRAIN.
  - IDLE->RUN on start.
  - RUN->DRAIN after issuing butterfly PTS/2-1.
  - DRAIN->RUN (stage+1) after the last write of a non-final stage.
  - DRAIN->IDLE after the last write of the final stage.
- REQ-016: In RUN, one butterfly k (0..PTS/2-1) SHALL be issued per cycle with rd_en=1.
  - span=2^stage.
  - a=((k>>stage)<<(stage+1)) + (k & (span-1)).
  - b=a+span.
  - tw_idx=(k & (span-1))<<(LOG2PTS-1-stage).
- REQ-017: wr_en, wr_addr_a and wr_addr_b SHALL equal rd_en, rd_addr_a and rd_addr_b delayed by D=BF_LAT+1 cycles, through a shift pipeline.
- REQ-018: The next stage SHALL NOT issue any read until every write of the current stage has been made. The first read of stage s+1 occurs the cycle after the last write of stage s.
- REQ-019: A pass SHALL take exactly LOG2PTS*(PTS/2+D) cycles of busy.
  - busy rises the cycle after start is accepted.
  - busy falls in the cycle done pulses.
  - done pulses the cycle after the final wr_en.
- REQ-020: start while busy SHALL be ignored. start in the done cycle (state IDLE) SHALL be accepted.
- REQ-021: When rd_en=0, read addresses and tw_idx SHALL be 0. When wr_en=0, write addresses SHALL be 0.

Reset
- REQ-022: rst SHALL force IDLE, and SHALL clear stage, k and the delay pipeline.
  - All outputs read 0 in the cycle after rst.
  - In-flight writes are discarded (no wr_en after rst).
- REQ-023: rst asserted together with start SHALL win; no pass begins.

Configuration
- REQ-024: With FFT_CTRL_CYCLE_CNT_EN defined, the block SHALL add output cyc_cnt (16 bits).
  - Cleared when start is accepted.
  - Incremented each busy cycle.
  - Held after done until the next start.
  - Cleared by rst.
- REQ-025: Without FFT_CTRL_CYCLE_CNT_EN, the cyc_cnt port and its counter SHALL be absent; all other behaviour is identical.

Verification (LOG2PTS=3, BF_LAT=1, D=2; start high at cycle 0)
- REQ-026: Stage 0 timing and addresses.
  - rd_en in cycles 1-4; pairs (0,1),(2,3),(4,5),(6,7); tw_idx 0,0,0,0.
  - wr_en in cycles 3-6 with the same pairs.
- REQ-027: Stage 1 timing and addresses.
  - Reads in cycles 7-10; pairs (0,2),(1,3),(4,6),(5,7); tw_idx 0,2,0,2; stage=1.
  - No read in cycles 5-6.
- REQ-028: Stage 2 timing and completion.
  - Reads in cycles 13-16; pairs (0,4),(1,5),(2,6),(3,7); tw_idx 0,1,2,3.
  - Writes in cycles 15-18.
  - done=1 only in cycle 19, with busy=0.
  - cyc_cnt=18 when FFT_CTRL_CYCLE_CNT_EN is defined.
- REQ-029: Start handling.
  - start pulsed at cycle 8: ignored; the schedule is unchanged.
  - start held high through cycle 19: second pass reads (0,1) at cycle 20.
- REQ-030: Reset mid-pass.
  - rst at cycle 10: all outputs 0 from cycle 11.
  - No wr_en for the in-flight butterflies.
  - start at cycle 12: a clean pass with first read at cycle 13.
